// File: rtl/exc_if.sv
// Pipeline-side bundle for the exception sequencer: EX-stage event flags and
// SR state in, SR stack strobes, fetch redirect and cause/EPC out.
interface exc_if #(
   parameter int N_IRQ = 8
);
   logic [N_IRQ-1:0] irq;
   logic             exc_sys;
   logic             exc_ill;
   logic             exc_ovf;
   logic             rfe_req;
   logic             ex_valid;
   logic [31:0]      pc_ex;
   logic             ie;
   logic             su;

   logic             exc_pulse;
   logic             rfe_pulse;
   logic             flush;
   logic             busy;
   logic             pc_load;
   logic [31:0]      pc_target;
   logic [4:0]       cause;
   logic [31:0]      epc;
   logic [N_IRQ-1:0] irq_ack;

   modport master (
      output irq, exc_sys, exc_ill, exc_ovf, rfe_req, ex_valid, pc_ex, ie, su,
      input  exc_pulse, rfe_pulse, flush, busy, pc_load, pc_target, cause, epc, irq_ack
   );

   modport slave (
      input  irq, exc_sys, exc_ill, exc_ovf, rfe_req, ex_valid, pc_ex, ie, su,
      output exc_pulse, rfe_pulse, flush, busy, pc_load, pc_target, cause, epc, irq_ack
   );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: arbitrates EX-stage exceptions, rfe and latched
// IRQs, then runs ENTER -> PUSH (exception) or RET (return) strobe sequences.
module exc_ctrl #(
   parameter int          N_IRQ    = 8,
   parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
   input logic   clk,
   input logic   rst,
   exc_if.slave  bus
);

   localparam logic [4:0] CAUSE_SYS = 5'h10;
   localparam logic [4:0] CAUSE_ILL = 5'h11;
   localparam logic [4:0] CAUSE_OVF = 5'h12;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTER = 2'd1,
      S_PUSH  = 2'd2,
      S_RET   = 2'd3
   } state_t;

   state_t           state_reg, state_next;

   logic [N_IRQ-1:0] irq_prev_reg;
   logic [N_IRQ-1:0] pend_reg;
   logic [N_IRQ-1:0] pend_next;
   logic [N_IRQ-1:0] irq_sel_reg;
   logic             is_irq_reg;
   logic [31:0]      last_pc_reg;
   logic [4:0]       cause_reg;
   logic [31:0]      epc_reg;

   logic [N_IRQ-1:0] irq_masked;
   logic [N_IRQ-1:0] irq_onehot;
   logic [4:0]       irq_idx;
   logic             irq_any;

   logic             load_evt;
   logic             take_irq;
   logic [4:0]       evt_cause;
   logic [31:0]      evt_epc;
   logic [N_IRQ-1:0] irq_ack_c;

   // Edge-latched pending bits; a new edge beats the acknowledge in the same cycle.
   generate
      for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
         assign pend_next[gi] = (bus.irq[gi] & ~irq_prev_reg[gi]) |
                                (pend_reg[gi] & ~irq_ack_c[gi]);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_prev_reg <= '0;
         pend_reg     <= '0;
      end else begin
         irq_prev_reg <= bus.irq;
         pend_reg     <= pend_next;
      end
   end

   // Interrupts enabled only while ie is high; lowest index has priority.
   assign irq_masked = pend_reg & {N_IRQ{bus.ie}};
   assign irq_any    = |irq_masked;

   always_comb begin
      irq_idx    = '0;
      irq_onehot = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (irq_masked[i]) begin
            irq_idx    = 5'(i);
            irq_onehot = '0;
            irq_onehot[i] = 1'b1;
         end
      end
   end

   // Last real PC in EX, used as the return point when an IRQ lands on a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_pc_reg <= '0;
      end else if (bus.ex_valid) begin
         last_pc_reg <= bus.pc_ex;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      load_evt   = 1'b0;
      take_irq   = 1'b0;
      evt_cause  = '0;
      evt_epc    = bus.pc_ex;
      case (state_reg)
         S_IDLE: begin
            if (bus.ex_valid && bus.exc_ovf) begin
               load_evt   = 1'b1;
               evt_cause  = CAUSE_OVF;
               state_next = S_ENTER;
            end else if (bus.ex_valid && bus.exc_ill) begin
               load_evt   = 1'b1;
               evt_cause  = CAUSE_ILL;
               state_next = S_ENTER;
            end else if (bus.ex_valid && bus.exc_sys) begin
               load_evt   = 1'b1;
               evt_cause  = CAUSE_SYS;
               state_next = S_ENTER;
            end else if (bus.ex_valid && bus.rfe_req) begin
               if (bus.su) begin
                  state_next = S_RET;
               end else begin
                  // rfe from user mode is a privilege violation
                  load_evt   = 1'b1;
                  evt_cause  = CAUSE_ILL;
                  state_next = S_ENTER;
               end
            end else if (irq_any) begin
               load_evt   = 1'b1;
               take_irq   = 1'b1;
               evt_cause  = irq_idx;
               evt_epc    = bus.ex_valid ? bus.pc_ex : last_pc_reg;
               state_next = S_ENTER;
            end
         end
         S_ENTER: state_next = S_PUSH;
         S_PUSH:  state_next = S_IDLE;
         S_RET:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cause_reg   <= '0;
         epc_reg     <= '0;
         is_irq_reg  <= 1'b0;
         irq_sel_reg <= '0;
      end else if (load_evt) begin
         cause_reg   <= evt_cause;
         epc_reg     <= evt_epc;
         is_irq_reg  <= take_irq;
         irq_sel_reg <= take_irq ? irq_onehot : '0;
      end
   end

   assign irq_ack_c = (state_reg == S_ENTER && is_irq_reg) ? irq_sel_reg : '0;

   always_comb begin
      bus.flush     = 1'b0;
      bus.busy      = 1'b0;
      bus.exc_pulse = 1'b0;
      bus.rfe_pulse = 1'b0;
      bus.pc_load   = 1'b0;
      bus.pc_target = '0;
      case (state_reg)
         S_ENTER: begin
            bus.flush = 1'b1;
            bus.busy  = 1'b1;
         end
         S_PUSH: begin
            bus.busy      = 1'b1;
            bus.exc_pulse = 1'b1;
            bus.pc_load   = 1'b1;
            bus.pc_target = VEC_BASE + {23'b0, cause_reg, 4'b0000};
         end
         S_RET: begin
            bus.flush     = 1'b1;
            bus.busy      = 1'b1;
            bus.rfe_pulse = 1'b1;
            bus.pc_load   = 1'b1;
            bus.pc_target = epc_reg;
         end
         default: ;
      endcase
   end

   assign bus.irq_ack = irq_ack_c;
   assign bus.cause   = cause_reg;
   assign bus.epc     = epc_reg;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: inputs driven and outputs sampled on the falling
// edge; strobe vector is {flush, busy, exc_pulse, rfe_pulse, pc_load}.
module tb_exc_ctrl;
   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   exc_if #(.N_IRQ(8)) bus ();

   exc_ctrl #(.N_IRQ(8), .VEC_BASE(32'h0000_0080)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] strobes();
      return {bus.flush, bus.busy, bus.exc_pulse, bus.rfe_pulse, bus.pc_load};
   endfunction

   task automatic clear_inputs();
      bus.exc_sys  = 1'b0;
      bus.exc_ill  = 1'b0;
      bus.exc_ovf  = 1'b0;
      bus.rfe_req  = 1'b0;
      bus.ex_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.irq = '0; bus.pc_ex = '0; bus.ie = 1'b0; bus.su = 1'b0;
      clear_inputs();
      @(negedge clk); @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b0 || bus.pc_target !== 32'h0 || bus.cause !== 5'h0 ||
          bus.epc !== 32'h0 || bus.irq_ack !== 8'h0) begin
         n_err++;
         $display("FAIL reset_outputs: strobes=%b tgt=%h cause=%h epc=%h ack=%h, required all 0",
                  strobes(), bus.pc_target, bus.cause, bus.epc, bus.irq_ack);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_vec++;
         if (strobes() !== 5'b0 || bus.irq_ack !== 8'h0) begin
            n_err++;
            $display("FAIL reset_idle[%0d]: strobes=%b ack=%h, required 0", i, strobes(), bus.irq_ack);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_overflow();
      bus.exc_ovf = 1'b1; bus.ex_valid = 1'b1; bus.pc_ex = 32'h100;
      @(negedge clk);
      clear_inputs();
      n_vec++;
      if (strobes() !== 5'b11000 || bus.cause !== 5'h12 || bus.epc !== 32'h100) begin
         n_err++;
         $display("FAIL ovf_enter: strobes=%b cause=%h epc=%h, required 11000 12 00000100",
                  strobes(), bus.cause, bus.epc);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b01101 || bus.pc_target !== 32'h0000_01A0) begin
         n_err++;
         $display("FAIL ovf_push: strobes=%b tgt=%h, required 01101 000001a0", strobes(), bus.pc_target);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b0) begin
         n_err++;
         $display("FAIL ovf_idle: strobes=%b, required 00000", strobes());
      end
      $display("test_overflow done");
   endtask

   // Services IRQ2 then IRQ5; epc falls back to last valid PC since EX is a bubble.
   task automatic service_2_then_5(input string tag);
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b11000 || bus.irq_ack !== 8'h04 || bus.cause !== 5'd2 || bus.epc !== 32'h100) begin
         n_err++;
         $display("FAIL %s_enter2: strobes=%b ack=%h cause=%h epc=%h, required 11000 04 02 00000100",
                  tag, strobes(), bus.irq_ack, bus.cause, bus.epc);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b01101 || bus.pc_target !== 32'h0A0 || bus.irq_ack !== 8'h00) begin
         n_err++;
         $display("FAIL %s_push2: strobes=%b tgt=%h ack=%h, required 01101 000000a0 00",
                  tag, strobes(), bus.pc_target, bus.irq_ack);
      end
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b11000 || bus.irq_ack !== 8'h20 || bus.cause !== 5'd5) begin
         n_err++;
         $display("FAIL %s_enter5: strobes=%b ack=%h cause=%h, required 11000 20 05",
                  tag, strobes(), bus.irq_ack, bus.cause);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b01101 || bus.pc_target !== 32'h0D0) begin
         n_err++;
         $display("FAIL %s_push5: strobes=%b tgt=%h, required 01101 000000d0", tag, strobes(), bus.pc_target);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b0) begin
         n_err++;
         $display("FAIL %s_idle: strobes=%b, required 00000", tag, strobes());
      end
   endtask

   task automatic test_irq_arbitration();
      bus.ie = 1'b1;
      bus.irq = 8'h24;
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b0) begin
         n_err++;
         $display("FAIL irq_latch_cycle: strobes=%b, required 00000", strobes());
      end
      service_2_then_5("irq_ie1");
      bus.irq = 8'h00;
      bus.ie = 1'b0;
      @(negedge clk);
      bus.irq = 8'h24;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++;
         if (strobes() !== 5'b0 || bus.irq_ack !== 8'h0) begin
            n_err++;
            $display("FAIL irq_masked[%0d]: strobes=%b ack=%h, required 00000 00", i, strobes(), bus.irq_ack);
         end
      end
      bus.ie = 1'b1;
      service_2_then_5("irq_pending");
      bus.irq = 8'h00;
      $display("test_irq_arbitration done");
   endtask

   task automatic test_rfe();
      bus.su = 1'b1; bus.rfe_req = 1'b1; bus.ex_valid = 1'b1; bus.pc_ex = 32'h300;
      @(negedge clk);
      clear_inputs();
      n_vec++;
      if (strobes() !== 5'b11011 || bus.pc_target !== 32'h100 || bus.epc !== 32'h100) begin
         n_err++;
         $display("FAIL rfe_ret: strobes=%b tgt=%h epc=%h, required 11011 00000100 00000100",
                  strobes(), bus.pc_target, bus.epc);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b0) begin
         n_err++;
         $display("FAIL rfe_idle: strobes=%b, required 00000", strobes());
      end
      bus.su = 1'b0; bus.rfe_req = 1'b1; bus.ex_valid = 1'b1; bus.pc_ex = 32'h304;
      @(negedge clk);
      clear_inputs();
      n_vec++;
      if (strobes() !== 5'b11000 || bus.cause !== 5'h11 || bus.epc !== 32'h304) begin
         n_err++;
         $display("FAIL rfe_user_enter: strobes=%b cause=%h epc=%h, required 11000 11 00000304",
                  strobes(), bus.cause, bus.epc);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b01101 || bus.pc_target !== 32'h190) begin
         n_err++;
         $display("FAIL rfe_user_push: strobes=%b tgt=%h, required 01101 00000190", strobes(), bus.pc_target);
      end
      @(negedge clk);
      $display("test_rfe done");
   endtask

   task automatic test_simultaneous();
      bus.ie = 1'b0;
      bus.irq = 8'h08;
      @(negedge clk);
      @(negedge clk);
      bus.ie = 1'b1; bus.su = 1'b1;
      bus.exc_sys = 1'b1; bus.rfe_req = 1'b1; bus.ex_valid = 1'b1; bus.pc_ex = 32'h400;
      @(negedge clk);
      clear_inputs();
      n_vec++;
      if (strobes() !== 5'b11000 || bus.cause !== 5'h10 || bus.epc !== 32'h400 || bus.irq_ack !== 8'h0) begin
         n_err++;
         $display("FAIL sim_enter_sys: strobes=%b cause=%h epc=%h ack=%h, required 11000 10 00000400 00",
                  strobes(), bus.cause, bus.epc, bus.irq_ack);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b01101 || bus.pc_target !== 32'h180) begin
         n_err++;
         $display("FAIL sim_push_sys: strobes=%b tgt=%h, required 01101 00000180", strobes(), bus.pc_target);
      end
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b11000 || bus.cause !== 5'd3 || bus.irq_ack !== 8'h08 || bus.epc !== 32'h400) begin
         n_err++;
         $display("FAIL sim_enter_irq: strobes=%b cause=%h ack=%h epc=%h, required 11000 03 08 00000400",
                  strobes(), bus.cause, bus.irq_ack, bus.epc);
      end
      @(negedge clk);
      n_vec++;
      if (strobes() !== 5'b01101 || bus.pc_target !== 32'h0B0) begin
         n_err++;
         $display("FAIL sim_push_irq: strobes=%b tgt=%h, required 01101 000000b0", strobes(), bus.pc_target);
      end
      bus.irq = 8'h00;
      @(negedge clk);
      $display("test_simultaneous done");
   endtask

   task automatic test_reset_mid_op();
      bus.exc_ill = 1'b1; bus.ex_valid = 1'b1; bus.pc_ex = 32'h500;
      @(negedge clk);
      clear_inputs();
      n_vec++;
      if (strobes() !== 5'b11000) begin
         n_err++;
         $display("FAIL midrst_enter: strobes=%b, required 11000", strobes());
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (strobes() !== 5'b0 || bus.cause !== 5'h0 || bus.epc !== 32'h0 || bus.pc_target !== 32'h0) begin
         n_err++;
         $display("FAIL midrst_async: strobes=%b cause=%h epc=%h tgt=%h, required all 0",
                  strobes(), bus.cause, bus.epc, bus.pc_target);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_vec++;
         if (strobes() !== 5'b0) begin
            n_err++;
            $display("FAIL midrst_after[%0d]: strobes=%b, required 00000", i, strobes());
         end
      end
      $display("test_reset_mid_op done");
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_overflow();
      test_irq_arbitration();
      test_rfe();
      test_simultaneous();
      test_reset_mid_op();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
